// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: state encoding, datapath
// select codes, ALU control codes, instruction class codes, condition codes,
// and the data-processing command decoder.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Unsupported commands fall back to ADD so the datapath stays defined.
  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: alu_decode = ALU_ADD;
      4'b0010: alu_decode = ALU_SUB;
      4'b0000: alu_decode = ALU_AND;
      4'b1100: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// Condition unit: holds the {N,Z,C,V} flags register and evaluates the
// instruction condition field against it.
// Ports:
//   clk, rst_n     clock, async active-low reset (clears flags)
//   i_cond         instruction condition field
//   i_alu_flags    {N,Z,C,V} from the ALU
//   i_flag_we      load enable for the flags register
//   o_cond_ex      condition passed (combinational from i_cond and flags)
//   o_flags        current flags register
module cond_unit
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_flag_we,
  output logic       o_cond_ex,
  output logic [3:0] o_flags
);

  logic [3:0] r_flags;
  logic       w_n, w_z, w_c, w_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_flags <= 4'b0000;
    else if (i_flag_we) r_flags <= i_alu_flags;
  end

  assign {w_n, w_z, w_c, w_v} = r_flags;
  assign o_flags = r_flags;

  always_comb begin
    o_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = (w_n == w_v);
      COND_LT: o_cond_ex = (w_n != w_v);
      COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: o_cond_ex = w_z | (w_n != w_v);
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset main controller (Moore FSM).
// state    | meaning
// FETCH    | read instruction, PC <= PC+4
// DECODE   | read registers, classify instruction
// MEMADR   | compute memory address
// MEMREAD  | read data memory
// MEMWB    | write loaded data to register file
// MEMWRITE | write data memory
// EXECUTER | data-processing, register operand
// EXECUTEI | data-processing, immediate operand
// ALUWB    | write ALU result (and PC when Rd=15)
// BRANCH   | PC <= branch target
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   i_cond/i_op/i_funct/i_rd    instruction fields
//   i_alu_flags                 {N,Z,C,V} from ALU
//   o_pc_write..o_mem_write     write enables
//   o_adr_src, o_alu_src_a, o_alu_src_b, o_result_src, o_alu_ctrl,
//   o_imm_src, o_reg_src        datapath selects
//   o_state, o_flags            debug visibility of FSM state and flags
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_cond,
  input  logic [1:0] i_op,
  input  logic [5:0] i_funct,
  input  logic [3:0] i_rd,
  input  logic [3:0] i_alu_flags,
  output logic       o_pc_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic       o_mem_write,
  output logic       o_adr_src,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_ctrl,
  output logic [1:0] o_imm_src,
  output logic [1:0] o_reg_src,
  output logic [3:0] o_state,
  output logic [3:0] o_flags
);

  state_t r_state, w_next;
  logic   w_cond_ex;
  logic   w_flag_we;

  // Flags only update on leaving an execute state with S set and the
  // condition passing; a failed condition leaves them untouched.
  assign w_flag_we = ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)) &&
                     i_funct[0] && w_cond_ex;

  cond_unit u_cond_unit (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cond      (i_cond),
    .i_alu_flags (i_alu_flags),
    .i_flag_we   (w_flag_we),
    .o_cond_ex   (w_cond_ex),
    .o_flags     (o_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  assign o_state   = r_state;
  assign o_imm_src = i_op;
  assign o_reg_src = {(i_op == OP_MEM), (i_op == OP_BR)};

  always_comb begin
    w_next       = S_FETCH;
    o_pc_write   = 1'b0;
    o_ir_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_write  = 1'b0;
    o_adr_src    = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_WD;
    o_result_src = RES_ALUOUT;
    o_alu_ctrl   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        o_ir_write   = 1'b1;
        o_pc_write   = 1'b1;
        o_alu_src_a  = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURES;
        w_next       = S_DECODE;
      end
      S_DECODE: begin
        o_alu_src_a  = 1'b1;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURES;
        case (i_op)
          OP_MEM:  w_next = S_MEMADR;
          OP_DP:   w_next = i_funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        o_alu_src_b = SRCB_IMM;
        w_next      = i_funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        o_adr_src = 1'b1;
        w_next    = S_MEMWB;
      end
      S_MEMWB: begin
        o_result_src = RES_DATA;
        o_reg_write  = w_cond_ex;
      end
      S_MEMWRITE: begin
        o_adr_src   = 1'b1;
        o_mem_write = w_cond_ex;
      end
      S_EXECUTER: begin
        o_alu_ctrl = alu_decode(i_funct[4:1]);
        w_next     = S_ALUWB;
      end
      S_EXECUTEI: begin
        o_alu_src_b = SRCB_IMM;
        o_alu_ctrl  = alu_decode(i_funct[4:1]);
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        o_reg_write = w_cond_ex;
        o_pc_write  = w_cond_ex && (i_rd == 4'hF);
      end
      S_BRANCH: begin
        o_alu_src_b  = SRCB_IMM;
        o_result_src = RES_ALURES;
        o_pc_write   = w_cond_ex;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i_cond;
  logic [1:0] i_op;
  logic [5:0] i_funct;
  logic [3:0] i_rd;
  logic [3:0] i_alu_flags;
  logic       o_pc_write, o_ir_write, o_reg_write, o_mem_write;
  logic       o_adr_src, o_alu_src_a;
  logic [1:0] o_alu_src_b, o_result_src, o_alu_ctrl, o_imm_src, o_reg_src;
  logic [3:0] o_state, o_flags;
  logic [11:0] w_outs;

  int vectors = 0;
  int miscompares = 0;

  multicycle_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cond       (i_cond),
    .i_op         (i_op),
    .i_funct      (i_funct),
    .i_rd         (i_rd),
    .i_alu_flags  (i_alu_flags),
    .o_pc_write   (o_pc_write),
    .o_ir_write   (o_ir_write),
    .o_reg_write  (o_reg_write),
    .o_mem_write  (o_mem_write),
    .o_adr_src    (o_adr_src),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_result_src (o_result_src),
    .o_alu_ctrl   (o_alu_ctrl),
    .o_imm_src    (o_imm_src),
    .o_reg_src    (o_reg_src),
    .o_state      (o_state),
    .o_flags      (o_flags)
  );

  always #5 clk = ~clk;

  // {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
  //  alu_src_b[1:0], result_src[1:0], alu_ctrl[1:0]}
  assign w_outs = {o_pc_write, o_ir_write, o_reg_write, o_mem_write, o_adr_src,
                   o_alu_src_a, o_alu_src_b, o_result_src, o_alu_ctrl};

  // Expected output bundle per state, written from the state table.
  function automatic logic [11:0] exp_out(input logic [3:0] st, input logic ce,
                                          input logic [1:0] alu, input logic rd15);
    case (st)
      4'd0:    exp_out = {6'b110001, 2'b10, 2'b10, 2'b00};
      4'd1:    exp_out = {6'b000001, 2'b10, 2'b10, 2'b00};
      4'd2:    exp_out = {6'b000000, 2'b01, 2'b00, 2'b00};
      4'd3:    exp_out = {6'b000010, 2'b00, 2'b00, 2'b00};
      4'd4:    exp_out = {2'b00, ce, 3'b000, 2'b00, 2'b01, 2'b00};
      4'd5:    exp_out = {3'b000, ce, 2'b10, 2'b00, 2'b00, 2'b00};
      4'd6:    exp_out = {6'b000000, 2'b00, 2'b00, alu};
      4'd7:    exp_out = {6'b000000, 2'b01, 2'b00, alu};
      4'd8:    exp_out = {ce & rd15, 1'b0, ce, 3'b000, 2'b00, 2'b00, 2'b00};
      4'd9:    exp_out = {ce, 5'b00000, 2'b01, 2'b10, 2'b00};
      default: exp_out = 12'h000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd,
                           input logic [3:0] af);
    i_cond = c; i_op = op; i_funct = f; i_rd = rd; i_alu_flags = af;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_instr(4'hE, 2'b00, 6'b001000, 4'd0, 4'hF);
    @(posedge clk);
    #1;
    vectors++;
    if ({o_state, o_flags} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset state/flags got %h/%h want 0/0", o_state, o_flags);
    end
    vectors++;
    if (w_outs !== exp_out(4'd0, 1'b0, 2'b00, 1'b0)) begin
      miscompares++;
      $display("FAIL reset outs got %03h want %03h", w_outs, exp_out(4'd0, 1'b0, 2'b00, 1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_ldr();
    logic [3:0] seq [0:4];
    seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    set_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'h0);
    vectors++;
    if ({o_imm_src, o_reg_src} !== 4'b0110) begin
      miscompares++;
      $display("FAIL ldr imm/reg src got %b/%b want 01/10", o_imm_src, o_reg_src);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({o_state, w_outs} !== {seq[i], exp_out(seq[i], 1'b1, 2'b00, 1'b0)}) begin
        miscompares++;
        $display("FAIL ldr cyc %0d got %h/%03h want %h/%03h", i, o_state, w_outs,
                 seq[i], exp_out(seq[i], 1'b1, 2'b00, 1'b0));
      end
      tick();
    end
    vectors++;
    if (o_state !== 4'd0) begin
      miscompares++;
      $display("FAIL ldr end state got %h want 0", o_state);
    end
  endtask

  task automatic test_str();
    logic [3:0] seq [0:3];
    seq = '{4'd0, 4'd1, 4'd2, 4'd5};
    set_instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'h0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({o_state, w_outs} !== {seq[i], exp_out(seq[i], 1'b1, 2'b00, 1'b0)}) begin
        miscompares++;
        $display("FAIL str cyc %0d got %h/%03h want %h/%03h", i, o_state, w_outs,
                 seq[i], exp_out(seq[i], 1'b1, 2'b00, 1'b0));
      end
      tick();
    end
    vectors++;
    if (o_state !== 4'd0) begin
      miscompares++;
      $display("FAIL str end state got %h want 0", o_state);
    end
  endtask

  task automatic test_subs_beq();
    logic [3:0] dp [0:3];
    logic [3:0] br [0:2];
    dp = '{4'd0, 4'd1, 4'd6, 4'd8};
    br = '{4'd0, 4'd1, 4'd9};
    set_instr(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({o_state, w_outs} !== {dp[i], exp_out(dp[i], 1'b1, 2'b01, 1'b0)}) begin
        miscompares++;
        $display("FAIL subs cyc %0d got %h/%03h want %h/%03h", i, o_state, w_outs,
                 dp[i], exp_out(dp[i], 1'b1, 2'b01, 1'b0));
      end
      tick();
    end
    vectors++;
    if (o_flags !== 4'b0100) begin
      miscompares++;
      $display("FAIL subs flags got %b want 0100", o_flags);
    end
    set_instr(4'h0, 2'b10, 6'b101000, 4'd0, 4'b0000);
    vectors++;
    if (o_reg_src !== 2'b01) begin
      miscompares++;
      $display("FAIL beq reg_src got %b want 01", o_reg_src);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({o_state, w_outs} !== {br[i], exp_out(br[i], 1'b1, 2'b00, 1'b0)}) begin
        miscompares++;
        $display("FAIL beq cyc %0d got %h/%03h want %h/%03h", i, o_state, w_outs,
                 br[i], exp_out(br[i], 1'b1, 2'b00, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_bne_not_taken();
    logic [3:0] br [0:2];
    br = '{4'd0, 4'd1, 4'd9};
    set_instr(4'h1, 2'b10, 6'b101000, 4'd0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({o_state, w_outs} !== {br[i], exp_out(br[i], 1'b0, 2'b00, 1'b0)}) begin
        miscompares++;
        $display("FAIL bne cyc %0d got %h/%03h want %h/%03h", i, o_state, w_outs,
                 br[i], exp_out(br[i], 1'b0, 2'b00, 1'b0));
      end
      tick();
    end
    vectors++;
    if (o_state !== 4'd0) begin
      miscompares++;
      $display("FAIL bne end state got %h want 0", o_state);
    end
  endtask

  task automatic test_add_pc();
    logic [3:0] dp [0:3];
    dp = '{4'd0, 4'd1, 4'd6, 4'd8};
    set_instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({o_state, w_outs} !== {dp[i], exp_out(dp[i], 1'b1, 2'b00, 1'b1)}) begin
        miscompares++;
        $display("FAIL addpc cyc %0d got %h/%03h want %h/%03h", i, o_state, w_outs,
                 dp[i], exp_out(dp[i], 1'b1, 2'b00, 1'b1));
      end
      tick();
    end
    vectors++;
    if (o_flags !== 4'b0100) begin
      miscompares++;
      $display("FAIL addpc flags got %b want 0100", o_flags);
    end
  endtask

  task automatic test_cond_fail();
    logic [3:0] dp [0:3];
    dp = '{4'd0, 4'd1, 4'd7, 4'd8};
    set_instr(4'h1, 2'b00, 6'b101001, 4'd4, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({o_state, w_outs} !== {dp[i], exp_out(dp[i], 1'b0, 2'b00, 1'b0)}) begin
        miscompares++;
        $display("FAIL cfail cyc %0d got %h/%03h want %h/%03h", i, o_state, w_outs,
                 dp[i], exp_out(dp[i], 1'b0, 2'b00, 1'b0));
      end
      tick();
    end
    vectors++;
    if (o_flags !== 4'b0100) begin
      miscompares++;
      $display("FAIL cfail flags got %b want 0100", o_flags);
    end
  endtask

  task automatic test_alu_decode();
    logic [3:0] cmd [0:5];
    logic [1:0] alu [0:5];
    cmd = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1111};
    alu = '{2'b00,   2'b01,   2'b10,   2'b11,   2'b00,   2'b00};
    for (int k = 0; k < 6; k++) begin
      set_instr(4'hE, 2'b00, {1'b0, cmd[k], 1'b0}, 4'd1, 4'h0);
      tick();
      tick();
      vectors++;
      if ({o_state, o_alu_ctrl} !== {4'd6, alu[k]}) begin
        miscompares++;
        $display("FAIL aludec cmd %b got %h/%b want 6/%b", cmd[k], o_state, o_alu_ctrl, alu[k]);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_cond_table();
    logic [3:0] fl [0:20];
    logic [3:0] cc [0:20];
    logic       ex [0:20];
    fl = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
           4'b1001, 4'b1001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
           4'b0010, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b1000, 4'b1000};
    cc = '{4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF,
           4'h2, 4'h3, 4'h8, 4'h9, 4'h0, 4'h1,
           4'h8, 4'h9, 4'hC, 4'hD, 4'hA, 4'hB};
    ex = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 21; k++) begin
      set_instr(4'hE, 2'b00, 6'b001001, 4'd5, fl[k]);
      for (int j = 0; j < 4; j++) tick();
      vectors++;
      if (o_flags !== fl[k]) begin
        miscompares++;
        $display("FAIL adds flags load got %b want %b", o_flags, fl[k]);
      end
      set_instr(cc[k], 2'b10, 6'b100000, 4'd0, 4'h0);
      tick();
      tick();
      vectors++;
      if ({o_state, o_pc_write} !== {4'd9, ex[k]}) begin
        miscompares++;
        $display("FAIL cond %h flags %b got %h/%b want 9/%b", cc[k], fl[k],
                 o_state, o_pc_write, ex[k]);
      end
      tick();
    end
  endtask

  task automatic test_undefined();
    set_instr(4'hE, 2'b11, 6'b000000, 4'hF, 4'h0);
    vectors++;
    if ({o_imm_src, o_reg_src} !== 4'b1100) begin
      miscompares++;
      $display("FAIL undef imm/reg src got %b/%b want 11/00", o_imm_src, o_reg_src);
    end
    tick();
    vectors++;
    if ({o_state, w_outs} !== {4'd1, exp_out(4'd1, 1'b1, 2'b00, 1'b1)}) begin
      miscompares++;
      $display("FAIL undef decode got %h/%03h want 1/%03h", o_state, w_outs,
               exp_out(4'd1, 1'b1, 2'b00, 1'b1));
    end
    tick();
    vectors++;
    if (o_state !== 4'd0) begin
      miscompares++;
      $display("FAIL undef back to fetch got %h want 0", o_state);
    end
  endtask

  task automatic test_reset_mid();
    set_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'h0);
    tick();
    tick();
    tick();
    vectors++;
    if ({o_state, o_flags} !== {4'd3, 4'b1000}) begin
      miscompares++;
      $display("FAIL rstmid pre got %h/%b want 3/1000", o_state, o_flags);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_state, o_flags} !== 8'h00) begin
      miscompares++;
      $display("FAIL rstmid async got %h/%b want 0/0000", o_state, o_flags);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({o_state, o_pc_write, o_ir_write} !== {4'd0, 2'b11}) begin
      miscompares++;
      $display("FAIL rstmid release got %h/%b%b want 0/11", o_state, o_pc_write, o_ir_write);
    end
    tick();
    vectors++;
    if (o_state !== 4'd1) begin
      miscompares++;
      $display("FAIL rstmid first edge got %h want 1", o_state);
    end
  endtask

  initial begin
    test_reset();
    test_ldr();
    test_str();
    test_subs_beq();
    test_bne_not_taken();
    test_add_pc();
    test_cond_fail();
    test_alu_decode();
    test_cond_table();
    test_undefined();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
